// File: rtl/enocoro_4b_pkg.sv
// Shared types and constants for the Enocoro-128v2 4-bit datapath front end.
package enocoro_4b_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 2 * NIB_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } nib_state_e;

    // A FIFO byte viewed as its two nibble halves
    typedef struct packed {
        logic [NIB_W-1:0] hi;
        logic [NIB_W-1:0] lo;
    } byte_nib_t;

endpackage : enocoro_4b_pkg

// File: rtl/enocoro_byte_fifo.sv
// Byte FIFO with wrap-around pointers and an occupancy count of 0..DEPTH.
module enocoro_byte_fifo
    import enocoro_4b_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [BYTE_W-1:0]          din,
    input  logic                       pop,
    output logic [BYTE_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule : enocoro_byte_fifo

// File: rtl/enocoro_nibble_serializer.sv
// Byte-to-nibble serializer feeding the nibble-serial GF(2^8) x2 stage.
// Define ENOCORO_RESULT_TAG_EN to drive res_valid/res_hi; otherwise they are tied low.
module enocoro_nibble_serializer
    import enocoro_4b_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [NIB_W-1:0]  d_out,
    output logic              mux_c,
    output logic              nib_valid,
    output logic              busy,
    output logic              res_valid,
    output logic              res_hi
);

    nib_state_e           state_q, state_d;
    logic [NIB_W-1:0]     d_out_q, d_out_d;
    logic                 mux_q, mux_d;
    logic                 nib_valid_q, nib_valid_d;
    logic [NIB_W-1:0]     hi_hold_q, hi_hold_d;
    logic                 pop_c;
    logic                 push_c;
    byte_nib_t            head;
    logic [BYTE_W-1:0]    fifo_dout;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign push_c     = byte_valid & ~fifo_full;
    assign head       = byte_nib_t'(fifo_dout);
    assign byte_ready = ~fifo_full;
    assign busy       = (state_q != ST_IDLE) | (fifo_count != '0);

    enocoro_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_c),
        .din     (byte_in),
        .pop     (pop_c),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state and next-output: L nibble on pop, H nibble from hi_hold one cycle later
    always_comb begin
        state_d     = state_q;
        d_out_d     = '0;
        mux_d       = 1'b1;
        nib_valid_d = 1'b0;
        hi_hold_d   = hi_hold_q;
        pop_c       = 1'b0;
        case (state_q)
            ST_LOW: begin
                d_out_d     = hi_hold_q;
                mux_d       = 1'b0;
                nib_valid_d = 1'b1;
                state_d     = ST_HIGH;
            end
            default: begin
                if (!fifo_empty) begin
                    pop_c       = 1'b1;
                    d_out_d     = head.lo;
                    nib_valid_d = 1'b1;
                    hi_hold_d   = head.hi;
                    state_d     = ST_LOW;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            d_out_q     <= '0;
            mux_q       <= 1'b1;
            nib_valid_q <= 1'b0;
            hi_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            d_out_q     <= d_out_d;
            mux_q       <= mux_d;
            nib_valid_q <= nib_valid_d;
            hi_hold_q   <= hi_hold_d;
        end
    end

    assign d_out     = d_out_q;
    assign mux_c     = mux_q;
    assign nib_valid = nib_valid_q;

`ifdef ENOCORO_RESULT_TAG_EN
    logic res_hi_q, res_hi_d;
    logic res_valid_q, res_valid_d;

    // Result low nibble shows during H, high nibble the cycle after H
    always_comb begin
        res_hi_d    = (state_q == ST_HIGH);
        res_valid_d = (state_d == ST_HIGH) | res_hi_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_hi_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            res_hi_q    <= res_hi_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_hi    = res_hi_q;
    assign res_valid = res_valid_q;
`else
    assign res_hi    = 1'b0;
    assign res_valid = 1'b0;
`endif

endmodule : enocoro_nibble_serializer
